sc_inst_encoder: RTL and testbench
==================================

Name: sc_inst_encoder

Overview:
- Program loader/assembler for the single-cycle computer: accepts one symbolic instruction per handshake (mnemonic code plus register/immediate fields) and encodes it into a 32-bit MIPS word.
- Writes each word sequentially into instruction memory from address 0.
- Encodes exactly the instruction subset the single-cycle control unit decodes, so bench programs and boot images are produced in hardware.

Parameters:
ADDR_W, 6, word-address width of the instruction memory port
DEPTH, 64, number of instruction words; must be <= 2**ADDR_W

Ports:
clock  in  1  system clock, rising edge
resetn  in  1  asynchronous active-low reset
in_valid  in  1  instruction fields valid
in_ready  out  1  encoder can accept this cycle
in_mnem  in  5  mnemonic code (see Behaviour)
in_rs  in  5  rs field
in_rt  in  5  rt field
in_rd  in  5  rd field
in_sa  in  5  shift amount
in_imm  in  26  imm16 in [15:0] for I-type; target26 for j/jal
in_last  in  1  this instruction ends the program
mem_we  out  1  instruction-memory write strobe
mem_addr  out  ADDR_W  word address
mem_data  out  32  encoded instruction
count  out  ADDR_W+1  words written so far
done  out  1  program complete (sticky)
err  out  1  illegal mnemonic or overflow (sticky)

Behaviour:
- Mnemonic codes: add0 sub1 and2 or3 xor4 sll5 srl6 sra7 jr8 addi9 andi10 ori11 xori12 lw13 sw14 beq15 bne16 lui17 j18 jal19. Codes 20-31 are illegal.
- R-type encoding: op=000000 | rs | rt | rd | sa | func.
  - func values: add 100000, sub 100010, and 100100, or 100101, xor 100110, sll 000000, srl 000010, sra 000011, jr 001000.
  - Field forcing: add/sub/and/or/xor force sa=0. sll/srl/sra force rs=0. jr keeps rs only; rt, rd and sa are forced to 0.
- I-type encoding: op | rs | rt | imm[15:0].
  - op values: addi 001000, andi 001100, ori 001101, xori 001110, lw 100011, sw 101011, beq 000100, bne 000101, lui 001111.
  - lui forces rs=0.
  - Fields are passed through unchecked; no sign handling is done here.
- J-type encoding: op | imm[25:0], with j 000010 and jal 000011.
- FSM states IDLE, LOAD, DONE, ERR. Reset enters IDLE.
  - IDLE/LOAD: in_ready=1. A transfer occurs when in_valid && in_ready.
  - On a legal transfer: the word is registered and presented the next cycle as mem_we=1 with mem_addr=count and mem_data=word; count increments in that same cycle. Latency is 1 cycle, throughput is 1 word per cycle, and back-to-back transfers are allowed.
  - A legal transfer with in_last=1 writes its word and then enters DONE.
  - An illegal mnemonic writes nothing and enters ERR with err=1.
  - Overflow: when count reaches DEPTH, in_ready drops. A transfer request in that state (in_valid=1) enters ERR with err=1.
  - DONE and ERR are terminal: in_ready=0, no writes, done/err held until resetn.
  - count saturates at DEPTH.
- Reset values: in_ready=0 during reset and 1 the first cycle after deassertion; mem_we=0, mem_addr=0, mem_data=0, count=0, done=0, err=0.
- Reset mid-operation is asynchronous: it immediately clears mem_we and the pending word. Any write not yet strobed is lost.
- Simultaneous events:
  - in_last on the DEPTH-th word: the word is written and the FSM goes to DONE, not ERR.
  - in_last with an illegal mnemonic: ERR.

Decomposition:
- Shared package (sc_isa_pkg) holds:
  - mnemonic code constants;
  - the opcode and func 6-bit constants above;
  - the field bit positions (op 31:26, rs 25:21, rt 20:16, rd 15:11, sa 10:6, func 5:0).
- The control unit and this encoder both use the package.
- One combinational sub-module, sc_inst_pack, maps mnem and fields to {word, legal}. The top holds the FSM, output register and counter.

Test Plan:
- Reset, then addi(9) rs0 rt1 imm5 -> next cycle mem_we=1, addr0, data 0x20010005; count=1.
- Back-to-back add(0) rs1 rt2 rd3, then sll(5) rt2 rd4 sa3 with nonzero rs -> 0x00221820 at addr0, then 0x000220C0 at addr1 (rs forced 0), on consecutive cycles.
- lw(13) rs1 rt5 imm4, then j(18) imm 0x10 with in_last=1 -> 0x8C250004 at addr0, 0x08000010 at addr1; done=1, in_ready=0; further in_valid causes no writes.
- Mnemonic 25 after one legal word -> no write; err=1; count stays 1; in_ready=0 until resetn.
- DEPTH=4: five legal words with no in_last -> four writes at addr0-3, in_ready low after the fourth, err=1 on the fifth request. The same run with in_last on the fourth word gives done=1, err=0.
- Assert resetn low in the cycle between accept and write -> no mem_we; all outputs return to reset values; the next accepted instruction writes at addr0.

Source files
------------

// File: rtl/sc_isa_pkg.sv
// sc_isa_pkg: mnemonic codes, opcode/func constants, field positions and word builders
package sc_isa_pkg;

    localparam logic [4:0] M_ADD  = 5'd0;
    localparam logic [4:0] M_SUB  = 5'd1;
    localparam logic [4:0] M_AND  = 5'd2;
    localparam logic [4:0] M_OR   = 5'd3;
    localparam logic [4:0] M_XOR  = 5'd4;
    localparam logic [4:0] M_SLL  = 5'd5;
    localparam logic [4:0] M_SRL  = 5'd6;
    localparam logic [4:0] M_SRA  = 5'd7;
    localparam logic [4:0] M_JR   = 5'd8;
    localparam logic [4:0] M_ADDI = 5'd9;
    localparam logic [4:0] M_ANDI = 5'd10;
    localparam logic [4:0] M_ORI  = 5'd11;
    localparam logic [4:0] M_XORI = 5'd12;
    localparam logic [4:0] M_LW   = 5'd13;
    localparam logic [4:0] M_SW   = 5'd14;
    localparam logic [4:0] M_BEQ  = 5'd15;
    localparam logic [4:0] M_BNE  = 5'd16;
    localparam logic [4:0] M_LUI  = 5'd17;
    localparam logic [4:0] M_J    = 5'd18;
    localparam logic [4:0] M_JAL  = 5'd19;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_XORI  = 6'b001110;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_LUI   = 6'b001111;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_JAL   = 6'b000011;

    localparam logic [5:0] FN_ADD = 6'b100000;
    localparam logic [5:0] FN_SUB = 6'b100010;
    localparam logic [5:0] FN_AND = 6'b100100;
    localparam logic [5:0] FN_OR  = 6'b100101;
    localparam logic [5:0] FN_XOR = 6'b100110;
    localparam logic [5:0] FN_SLL = 6'b000000;
    localparam logic [5:0] FN_SRL = 6'b000010;
    localparam logic [5:0] FN_SRA = 6'b000011;
    localparam logic [5:0] FN_JR  = 6'b001000;

    localparam int OP_HI = 31, OP_LO = 26;
    localparam int RS_HI = 25, RS_LO = 21;
    localparam int RT_HI = 20, RT_LO = 16;
    localparam int RD_HI = 15, RD_LO = 11;
    localparam int SA_HI = 10, SA_LO = 6;
    localparam int FN_HI = 5,  FN_LO = 0;

    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_DONE, S_ERR} enc_state_e;

    function automatic logic [31:0] r_word(logic [4:0] rs, logic [4:0] rt, logic [4:0] rd,
                                           logic [4:0] sa, logic [5:0] fn);
        logic [31:0] w;
        w = '0;
        w[OP_HI:OP_LO] = OP_RTYPE;
        w[RS_HI:RS_LO] = rs;
        w[RT_HI:RT_LO] = rt;
        w[RD_HI:RD_LO] = rd;
        w[SA_HI:SA_LO] = sa;
        w[FN_HI:FN_LO] = fn;
        return w;
    endfunction

    function automatic logic [31:0] i_word(logic [5:0] op, logic [4:0] rs, logic [4:0] rt,
                                           logic [15:0] imm);
        logic [31:0] w;
        w = '0;
        w[OP_HI:OP_LO] = op;
        w[RS_HI:RS_LO] = rs;
        w[RT_HI:RT_LO] = rt;
        w[15:0]        = imm;
        return w;
    endfunction

    function automatic logic [31:0] j_word(logic [5:0] op, logic [25:0] target);
        logic [31:0] w;
        w = '0;
        w[OP_HI:OP_LO] = op;
        w[25:0]        = target;
        return w;
    endfunction

endpackage

// File: rtl/sc_inst_pack.sv
// sc_inst_pack: combinational map of mnemonic + fields to a MIPS word and a legal flag
// Ports: mnem/rs/rt/rd/sa/imm in; word (encoded instruction), legal (mnemonic in 0..19) out
module sc_inst_pack
    import sc_isa_pkg::*;
(
    input  logic [4:0]  mnem,
    input  logic [4:0]  rs,
    input  logic [4:0]  rt,
    input  logic [4:0]  rd,
    input  logic [4:0]  sa,
    input  logic [25:0] imm,
    output logic [31:0] word,
    output logic        legal
);
    always_comb begin
        word  = '0;
        legal = 1'b1;
        case (mnem)
            M_ADD:   word = r_word(rs, rt, rd, 5'd0, FN_ADD);
            M_SUB:   word = r_word(rs, rt, rd, 5'd0, FN_SUB);
            M_AND:   word = r_word(rs, rt, rd, 5'd0, FN_AND);
            M_OR:    word = r_word(rs, rt, rd, 5'd0, FN_OR);
            M_XOR:   word = r_word(rs, rt, rd, 5'd0, FN_XOR);
            M_SLL:   word = r_word(5'd0, rt, rd, sa, FN_SLL);
            M_SRL:   word = r_word(5'd0, rt, rd, sa, FN_SRL);
            M_SRA:   word = r_word(5'd0, rt, rd, sa, FN_SRA);
            M_JR:    word = r_word(rs, 5'd0, 5'd0, 5'd0, FN_JR);
            M_ADDI:  word = i_word(OP_ADDI, rs, rt, imm[15:0]);
            M_ANDI:  word = i_word(OP_ANDI, rs, rt, imm[15:0]);
            M_ORI:   word = i_word(OP_ORI, rs, rt, imm[15:0]);
            M_XORI:  word = i_word(OP_XORI, rs, rt, imm[15:0]);
            M_LW:    word = i_word(OP_LW, rs, rt, imm[15:0]);
            M_SW:    word = i_word(OP_SW, rs, rt, imm[15:0]);
            M_BEQ:   word = i_word(OP_BEQ, rs, rt, imm[15:0]);
            M_BNE:   word = i_word(OP_BNE, rs, rt, imm[15:0]);
            M_LUI:   word = i_word(OP_LUI, 5'd0, rt, imm[15:0]);
            M_J:     word = j_word(OP_J, imm);
            M_JAL:   word = j_word(OP_JAL, imm);
            default: legal = 1'b0;
        endcase
    end
endmodule

// File: rtl/sc_inst_encoder.sv
// sc_inst_encoder: accepts symbolic instructions and writes encoded words to instruction memory
// Ports: clock/resetn; in_* handshake with instruction fields; mem_we/mem_addr/mem_data write port;
//        count (words written), done (program complete), err (illegal mnemonic or overflow)
module sc_inst_encoder
    import sc_isa_pkg::*;
#(
    parameter int ADDR_W = 6,
    parameter int DEPTH  = 64
) (
    input  logic              clock,
    input  logic              resetn,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [4:0]        in_mnem,
    input  logic [4:0]        in_rs,
    input  logic [4:0]        in_rt,
    input  logic [4:0]        in_rd,
    input  logic [4:0]        in_sa,
    input  logic [25:0]       in_imm,
    input  logic              in_last,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_data,
    output logic [ADDR_W:0]   count,
    output logic              done,
    output logic              err
);
    localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W + 1)'(DEPTH);

    enc_state_e        state_q, state_d;
    logic              we_q;
    logic [ADDR_W-1:0] addr_q;
    logic [31:0]       data_q;
    logic [ADDR_W:0]   count_q;
    logic [31:0]       word;
    logic              legal;
    logic              active, full, xfer, accept;

    sc_inst_pack u_pack (
        .mnem  (in_mnem),
        .rs    (in_rs),
        .rt    (in_rt),
        .rd    (in_rd),
        .sa    (in_sa),
        .imm   (in_imm),
        .word  (word),
        .legal (legal)
    );

    assign active   = (state_q == S_IDLE) || (state_q == S_LOAD);
    assign full     = (count_q == DEPTH_C);
    // resetn gates ready so nothing looks acceptable while reset is held
    assign in_ready = resetn && active && !full;
    assign xfer     = in_valid && in_ready;
    assign accept   = xfer && legal;

    // a request while full is an overflow; in_last only matters on a legal accept
    always_comb begin
        state_d = xfer ? (!legal ? S_ERR : (in_last ? S_DONE : S_LOAD))
                       : ((active && full && in_valid) ? S_ERR : state_q);
    end

    // count advances together with the strobe, so mem_addr carries the pre-increment value
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state_q <= S_IDLE;
            we_q    <= 1'b0;
            addr_q  <= '0;
            data_q  <= '0;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            we_q    <= accept;
            if (accept) begin
                addr_q  <= count_q[ADDR_W-1:0];
                data_q  <= word;
                count_q <= count_q + 1'b1;
            end
        end
    end

    assign mem_we   = we_q;
    assign mem_addr = addr_q;
    assign mem_data = data_q;
    assign count    = count_q;
    assign done     = (state_q == S_DONE);
    assign err      = (state_q == S_ERR);
endmodule

// File: tb/tb_sc_inst_encoder.sv
// tb_sc_inst_encoder: directed and randomized checks of sc_inst_encoder against a behavioural model
module tb_sc_inst_encoder;
    localparam int ADDR_W = 3;
    localparam int DEPTH  = 4;

    logic              clock = 1'b0;
    logic              resetn = 1'b0;
    logic              in_valid = 1'b0;
    logic              in_ready;
    logic [4:0]        in_mnem = '0, in_rs = '0, in_rt = '0, in_rd = '0, in_sa = '0;
    logic [25:0]       in_imm = '0;
    logic              in_last = 1'b0;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_data;
    logic [ADDR_W:0]   count;
    logic              done, err;

    int n_checks = 0;
    int n_errors = 0;

    int          m_count;
    bit          m_done, m_err, e_we;
    int          e_addr;
    logic [31:0] e_data;

    sc_inst_encoder #(.ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
        .clock    (clock),
        .resetn   (resetn),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_mnem  (in_mnem),
        .in_rs    (in_rs),
        .in_rt    (in_rt),
        .in_rd    (in_rd),
        .in_sa    (in_sa),
        .in_imm   (in_imm),
        .in_last  (in_last),
        .mem_we   (mem_we),
        .mem_addr (mem_addr),
        .mem_data (mem_data),
        .count    (count),
        .done     (done),
        .err      (err)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Encoding straight from the instruction-set tables, built with shifts and masks
    function automatic logic [31:0] ref_enc(input int m, input int rs, input int rt, input int rd,
                                            input int sa, input int imm, output bit legal);
        int fn_tab[9] = '{32, 34, 36, 37, 38, 0, 2, 3, 8};
        int op_tab[9] = '{8, 12, 13, 14, 35, 43, 4, 5, 15};
        legal = 1;
        if (m <= 8) begin
            if (m >= 5 && m <= 7) rs = 0;
            if (m == 8) begin rt = 0; rd = 0; end
            if (m <= 4 || m == 8) sa = 0;
            return 32'((rs << 21) | (rt << 16) | (rd << 11) | (sa << 6) | fn_tab[m]);
        end
        if (m <= 17) begin
            if (m == 17) rs = 0;
            return 32'((op_tab[m-9] << 26) | (rs << 21) | (rt << 16) | (imm & 32'hFFFF));
        end
        if (m <= 19) return 32'(((m == 18 ? 2 : 3) << 26) | (imm & 32'h3FFFFFF));
        legal = 0;
        return 32'd0;
    endfunction

    task automatic model_reset();
        m_count = 0; m_done = 0; m_err = 0; e_we = 0; e_addr = 0; e_data = '0;
    endtask

    task automatic do_reset();
        resetn = 1'b0;
        in_valid = 1'b0;
        #1;
        check("rst_ready", in_ready, 0);
        check("rst_we", mem_we, 0);
        check("rst_addr", mem_addr, 0);
        check("rst_data", mem_data, 0);
        check("rst_count", count, 0);
        check("rst_done", done, 0);
        check("rst_err", err, 0);
        @(negedge clock);
        resetn = 1'b1;
        model_reset();
    endtask

    // One cycle: drive, check ready, advance the model at the edge, check registered outputs
    task automatic step(input bit v, input int m, input int rs, input int rt, input int rd,
                        input int sa, input int imm, input bit last);
        bit ready, legal;
        logic [31:0] w;
        in_valid = v; in_mnem = 5'(m); in_rs = 5'(rs); in_rt = 5'(rt); in_rd = 5'(rd);
        in_sa = 5'(sa); in_imm = 26'(imm); in_last = last;
        w = ref_enc(m, rs, rt, rd, sa, imm, legal);
        ready = !m_done && !m_err && m_count < DEPTH;
        #1;
        check("ready", in_ready, ready);
        @(posedge clock);
        e_we = 0;
        if (v) begin
            if (!ready) begin
                if (!m_done && !m_err) m_err = 1;
            end else if (!legal) m_err = 1;
            else begin
                e_we = 1; e_addr = m_count; e_data = w; m_count++;
                if (last) m_done = 1;
            end
        end
        @(negedge clock);
        in_valid = 1'b0;
        check("we", mem_we, e_we);
        if (e_we) begin
            check("addr", mem_addr, e_addr);
            check("data", mem_data, e_data);
        end
        check("count", count, m_count);
        check("done", done, m_done);
        check("err", err, m_err);
    endtask

    initial begin
        do_reset();
        step(1, 9, 0, 1, 0, 0, 5, 0);
        check("addi_word", mem_data, 32'h20010005);
        check("addi_count", count, 1);

        do_reset();
        step(1, 0, 1, 2, 3, 7, 0, 0);
        check("add_word", mem_data, 32'h00221820);
        step(1, 5, 9, 2, 4, 3, 0, 0);
        check("sll_word", mem_data, 32'h000220C0);
        check("sll_addr", mem_addr, 1);

        do_reset();
        step(1, 13, 1, 5, 0, 0, 4, 0);
        check("lw_word", mem_data, 32'h8C250004);
        step(1, 18, 0, 0, 0, 0, 'h10, 1);
        check("j_word", mem_data, 32'h08000010);
        check("j_done", done, 1);
        step(1, 0, 1, 2, 3, 0, 0, 0);
        check("after_done_we", mem_we, 0);

        do_reset();
        step(1, 11, 3, 4, 0, 0, 'hBEEF, 0);
        step(1, 25, 1, 1, 1, 1, 1, 1);
        check("illegal_err", err, 1);
        check("illegal_count", count, 1);
        step(1, 9, 1, 1, 0, 0, 1, 0);

        do_reset();
        for (int i = 0; i < 5; i++) step(1, 14, i, i + 1, 0, 0, i * 4, 0);
        check("ovf_err", err, 1);
        check("ovf_count", count, DEPTH);

        do_reset();
        for (int i = 0; i < 4; i++) step(1, 1, i, 2, 3, 0, 0, i == 3);
        check("full_last_done", done, 1);
        check("full_last_err", err, 0);
        step(1, 1, 0, 0, 0, 0, 0, 0);

        do_reset();
        in_valid = 1; in_mnem = 5'd9; in_rs = 0; in_rt = 1; in_imm = 26'd5; in_last = 0;
        @(posedge clock);
        #2 resetn = 1'b0;
        in_valid = 0;
        #1;
        check("midrst_we", mem_we, 0);
        check("midrst_data", mem_data, 0);
        check("midrst_count", count, 0);
        check("midrst_ready", in_ready, 0);
        @(negedge clock);
        resetn = 1'b1;
        model_reset();
        step(1, 4, 6, 7, 8, 9, 0, 0);
        check("midrst_addr", mem_addr, 0);

        for (int p = 0; p < 40; p++) begin
            do_reset();
            for (int s = 0; s < 7; s++) begin
                int m;
                m = ($urandom_range(0, 9) == 0) ? $urandom_range(20, 31) : $urandom_range(0, 19);
                step($urandom_range(0, 4) != 0, m, $urandom_range(0, 31), $urandom_range(0, 31),
                     $urandom_range(0, 31), $urandom_range(0, 31), int'($urandom() & 32'h3FFFFFF),
                     $urandom_range(0, 5) == 0);
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
